// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx: 8N1 serial receiver with an internal 16x oversample tick and valid/ready output.
// Define SDU_RX_PARITY_EN to receive 8E1 frames and drive parity_err_o.
module sdu_uart_rx #(
    parameter int unsigned DIV = 651,
    parameter int unsigned OVS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ScW  = $clog2(OVS);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [ScW-1:0]  ScMid   = ScW'(OVS / 2 - 1);
    localparam logic [ScW-1:0]  ScLast  = ScW'(OVS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef SDU_RX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4,
        StBreak  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            rxd_meta_q, rxd_s_q;
    logic [DivW-1:0] div_q;
    logic [ScW-1:0]  sc_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q, m_data_q;
    logic            m_valid_q, frame_err_q, overrun_q;
    logic            tick, bit_end, start_det, sc_clr, shift_en, stop_good, stop_bad;
    logic            commit, drop;
`ifdef SDU_RX_PARITY_EN
    logic            par_en, parity_bad_q, parity_err_q;
`endif

    assign tick    = (div_q == DivLast);
    assign bit_end = tick && (sc_q == ScLast);
    // A completed byte is dropped only if the previous one is still unclaimed this cycle.
    assign commit  = stop_good && (!m_valid_q || m_ready_i);
    assign drop    = stop_good && m_valid_q && !m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!rxd_s_q) state_d = StStart;
            StStart:  if (tick && sc_q == ScMid) state_d = rxd_s_q ? StIdle : StData;
`ifdef SDU_RX_PARITY_EN
            StData:   if (bit_end && bit_idx_q == 3'd7) state_d = StParity;
            StParity: if (bit_end) state_d = StStop;
`else
            StData:   if (bit_end && bit_idx_q == 3'd7) state_d = StStop;
`endif
            StStop:   if (bit_end) state_d = rxd_s_q ? StIdle : StBreak;
            StBreak:  if (rxd_s_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        sc_clr    = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
`ifdef SDU_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        busy_o    = (state_q != StIdle);
        unique case (state_q)
            StIdle:   start_det = !rxd_s_q;
            StStart:  sc_clr = tick && (sc_q == ScMid);
            StData:   shift_en = bit_end;
`ifdef SDU_RX_PARITY_EN
            StParity: par_en = bit_end;
`endif
            StStop: begin
                stop_good = bit_end && rxd_s_q;
                stop_bad  = bit_end && !rxd_s_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta_q   <= 1'b1;
            rxd_s_q      <= 1'b1;
            div_q        <= '0;
            sc_q         <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SDU_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
            // Restarting the divider on the start edge aligns tick phase to the frame.
            if (start_det || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DivW'(1);
            end
            if (start_det || sc_clr || bit_end) begin
                sc_q <= '0;
            end else if (tick) begin
                sc_q <= sc_q + ScW'(1);
            end
            if (sc_clr) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rxd_s_q, shift_q[7:1]};
            end
            if (commit) begin
                m_data_q  <= shift_q;
                m_valid_q <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end
            frame_err_q <= stop_bad;
            overrun_q   <= drop;
`ifdef SDU_RX_PARITY_EN
            if (par_en) begin
                parity_bad_q <= (rxd_s_q != ^shift_q);
            end
            parity_err_q <= stop_good && parity_bad_q;
`endif
        end
    end

    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef SDU_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdu_uart_rx.sv
// tb_sdu_uart_rx: directed frames into sdu_uart_rx (DIV=4, OVS=16 -> 64 clk per bit).
// Output events are counted on the falling clock edge; checks compare count deltas.
module tb_sdu_uart_rx;

    localparam int unsigned Div = 4;
    localparam int unsigned Ovs = 16;
    localparam int BitClk = Div * Ovs;
`ifdef SDU_RX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    // Sync + edge + bits up to stop + half a bit to the stop sample.
    localparam int LatExp = 3 + (FrameBits - 1) * BitClk + BitClk / 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rxd_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       busy_o;

    sdu_uart_rx #(
        .DIV(Div),
        .OVS(Ovs)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rxd_i       (rxd_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int         acc_cnt = 0, vcyc_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] acc_data = 8'h00;
    logic       valid_prev = 1'b0;

    always @(negedge clk_i) begin
        if (m_valid_o && m_ready_i) begin
            acc_cnt++;
            acc_data = m_data_o;
        end
        if (m_valid_o) vcyc_cnt++;
        if (m_valid_o && !valid_prev) rise_cyc = cyc;
        valid_prev = m_valid_o;
        if (frame_err_o) fe_cnt++;
        if (parity_err_o) pe_cnt++;
        if (overrun_o) ov_cnt++;
    end

    int n_checks = 0;
    int n_errs   = 0;
    int s_acc, s_vcyc, s_fe, s_pe, s_ov;
    int fall_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_acc  = acc_cnt;
        s_vcyc = vcyc_cnt;
        s_fe   = fe_cnt;
        s_pe   = pe_cnt;
        s_ov   = ov_cnt;
    endtask

    task automatic send_bit(input logic b);
        rxd_i = b;
        repeat (BitClk) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SDU_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
        rxd_i = 1'b1;
    endtask

`ifdef SDU_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        rxd_i = 1'b1;
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int lat;
        rst_i     = 1'b1;
        rxd_i     = 1'b1;
        m_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_valid", 32'(m_valid_o), 32'h0);
        check_eq("rst_data", 32'(m_data_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_flags", 32'({frame_err_o, parity_err_o, overrun_o}), 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(10);

        // Single byte, consumer always ready.
        m_ready_i = 1'b1;
        snap();
        send_frame(8'h55, 1'b1);
        idle(BitClk);
        lat = rise_cyc - fall_cyc;
        check_eq("b55_acc", 32'(acc_cnt - s_acc), 32'd1);
        check_eq("b55_data", 32'(acc_data), 32'h55);
        check_eq("b55_vcyc", 32'(vcyc_cnt - s_vcyc), 32'd1);
        check_eq("b55_lat", 32'(lat >= LatExp - 1 && lat <= LatExp + 1), 32'd1);
        check_eq("b55_flags", 32'((fe_cnt - s_fe) + (pe_cnt - s_pe) + (ov_cnt - s_ov)), 32'd0);

        // Back-to-back frames with the consumer stalled.
        m_ready_i = 1'b0;
        snap();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(BitClk);
        check_eq("ovr_valid", 32'(m_valid_o), 32'h1);
        check_eq("ovr_data", 32'(m_data_o), 32'hA3);
        check_eq("ovr_pulses", 32'(ov_cnt - s_ov), 32'd1);
        check_eq("ovr_noacc", 32'(acc_cnt - s_acc), 32'd0);
        m_ready_i = 1'b1;
        @(posedge clk_i);
        #1 m_ready_i = 1'b0;
        @(negedge clk_i);
        check_eq("ovr_acc", 32'(acc_cnt - s_acc), 32'd1);
        check_eq("ovr_accdata", 32'(acc_data), 32'hA3);
        check_eq("ovr_drop", 32'(m_valid_o), 32'h0);

        // Start-bit glitch of 20 clk.
        idle(BitClk);
        snap();
        rxd_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("gl_busy", 32'(busy_o), 32'h1);
        repeat (10) @(posedge clk_i);
        #1 rxd_i = 1'b1;
        repeat (19) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("gl_idle", 32'(busy_o), 32'h0);
        idle(BitClk * FrameBits);
        check_eq("gl_vcyc", 32'(vcyc_cnt - s_vcyc), 32'd0);
        check_eq("gl_flags", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov) + (pe_cnt - s_pe)), 32'd0);

        // Stop bit 0 followed by a held-low break.
        m_ready_i = 1'b1;
        snap();
        send_frame(8'h7E, 1'b0);
        rxd_i = 1'b0;
        @(negedge clk_i);
        check_eq("brk_busy0", 32'(busy_o), 32'h1);
        idle(2 * BitClk - 1);
        @(negedge clk_i);
        check_eq("brk_busy1", 32'(busy_o), 32'h1);
        @(posedge clk_i);
        #1 rxd_i = 1'b1;
        idle(10);
        @(negedge clk_i);
        check_eq("brk_idle", 32'(busy_o), 32'h0);
        check_eq("brk_fe", 32'(fe_cnt - s_fe), 32'd1);
        check_eq("brk_vcyc", 32'(vcyc_cnt - s_vcyc), 32'd0);
        idle(BitClk);
        m_ready_i = 1'b0;
        send_frame(8'h01, 1'b1);
        idle(BitClk);
        check_eq("brk_next_valid", 32'(m_valid_o), 32'h1);
        check_eq("brk_next_data", 32'(m_data_o), 32'h01);

        // Reset in the middle of data bit 4 while 0x01 is still pending.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rxd_i = 1'b1;
        idle(BitClk / 2);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("mid_rst_valid", 32'(m_valid_o), 32'h0);
        check_eq("mid_rst_data", 32'(m_data_o), 32'h0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'h0);
        snap();
        m_ready_i = 1'b1;
        idle(6 * BitClk);
        check_eq("mid_rst_vcyc", 32'(vcyc_cnt - s_vcyc), 32'd0);
        send_frame(8'h96, 1'b1);
        idle(BitClk);
        check_eq("after_rst_acc", 32'(acc_cnt - s_acc), 32'd1);
        check_eq("after_rst_data", 32'(acc_data), 32'h96);

`ifdef SDU_RX_PARITY_EN
        snap();
        send_frame_par(8'h07, 1'b1, 1'b1);
        idle(BitClk);
        check_eq("par_ok_data", 32'(acc_data), 32'h07);
        check_eq("par_ok_pe", 32'(pe_cnt - s_pe), 32'd0);
        snap();
        send_frame_par(8'h07, 1'b0, 1'b1);
        idle(BitClk);
        check_eq("par_bad_acc", 32'(acc_cnt - s_acc), 32'd1);
        check_eq("par_bad_data", 32'(acc_data), 32'h07);
        check_eq("par_bad_pe", 32'(pe_cnt - s_pe), 32'd1);
`else
        check_eq("pe_never", 32'(pe_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
